// File: rtl/bus_arbiter_2_if.sv
// bus_arbiter_2_if: requester A/B handshakes plus the downstream valid/ready stream.
// The slave modport is the arbiter side; the master modport is the requesters/consumer side.
interface bus_arbiter_2_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_a;
  logic             last_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             grant_a;
  logic             req_b;
  logic             last_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             grant_b;
  logic             sel_mux;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  req_a, last_a, data_a, req_b, last_b, data_b, out_ready,
    output ack_a, grant_a, ack_b, grant_b, sel_mux, out_valid, out_data
  );

  modport master (
    output req_a, last_a, data_a, req_b, last_b, data_b, out_ready,
    input  ack_a, grant_a, ack_b, grant_b, sel_mux, out_valid, out_data
  );
endinterface

// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-requester round-robin arbiter owning a shared mux and registered output stage.
// Define ARB_BEAT_LIMIT_EN to release a grant after MAX_BEATS beats when the other side is waiting.
module bus_arbiter_2 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BEATS = 8
) (
  input logic            clk,
  input logic            rst,
  bus_arbiter_2_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;  // 1: B was served last
  logic             grant_a_q, grant_a_d;
  logic             grant_b_q, grant_b_d;
  logic             sel_mux_q, sel_mux_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mux_data;
  logic             slot_free;
  logic             ack_a, ack_b;
  logic             limit_a, limit_b;

  if (MAX_BEATS < 2 || MAX_BEATS > 256) begin : g_max_beats_check
    $error("bus_arbiter_2: MAX_BEATS must be within 2..256");
  end

`ifdef ARB_BEAT_LIMIT_EN
  localparam int unsigned      CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_inc;

  // Saturating count so a lone requester can keep streaming past the limit.
  always_comb begin
    beat_cnt_inc = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;
    limit_a      = (beat_cnt_inc == CNT_MAX) && bus.req_b;
    limit_b      = (beat_cnt_inc == CNT_MAX) && bus.req_a;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d == IDLE) begin
      beat_cnt_d = '0;
    end else if (ack_a || ack_b) begin
      beat_cnt_d = beat_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign limit_a = 1'b0;
  assign limit_b = 1'b0;
`endif

  assign slot_free = !out_valid_q || bus.out_ready;
  assign mux_data  = sel_mux_q ? bus.data_b : bus.data_a;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    grant_a_d   = grant_a_q;
    grant_b_d   = grant_b_q;
    sel_mux_d   = sel_mux_q;
    ack_a       = 1'b0;
    ack_b       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || rr_last_q)) begin
          state_d   = OWN_A;
          grant_a_d = 1'b1;
          sel_mux_d = 1'b0;
        end else if (bus.req_b) begin
          state_d   = OWN_B;
          grant_b_d = 1'b1;
          sel_mux_d = 1'b1;
        end
      end
      OWN_A: begin
        ack_a = bus.req_a && slot_free;
        if (ack_a && (bus.last_a || limit_a)) begin
          state_d   = IDLE;
          rr_last_d = 1'b0;
          grant_a_d = 1'b0;
        end
      end
      OWN_B: begin
        ack_b = bus.req_b && slot_free;
        if (ack_b && (bus.last_b || limit_b)) begin
          state_d   = IDLE;
          rr_last_d = 1'b1;
          grant_b_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
      end
    endcase
  end

  // Output stage drains independently of ownership, including while IDLE.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (ack_a || ack_b) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      grant_a_q   <= 1'b0;
      grant_b_q   <= 1'b0;
      sel_mux_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      grant_a_q   <= grant_a_d;
      grant_b_q   <= grant_b_d;
      sel_mux_q   <= sel_mux_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.grant_a   = grant_a_q;
  assign bus.grant_b   = grant_b_q;
  assign bus.sel_mux   = sel_mux_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb_bus_arbiter_2: directed scenarios for bus_arbiter_2, inputs driven after negedge, outputs sampled 1ns later.
// ARB_BEAT_LIMIT_EN selects which beat-limit scenario is exercised.
module tb_bus_arbiter_2;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bus_arbiter_2_if #(.WIDTH(16)) bus ();

  bus_arbiter_2 #(.WIDTH(16), .MAX_BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.last_a = 1'b1; bus.last_b = 1'b1;
    bus.data_a = 16'h1234; bus.data_b = 16'h5678; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.grant_a, bus.grant_b} !== 2'b00) begin errors++; $display("FAIL reset_grants: got %b want 00", {bus.grant_a, bus.grant_b}); end
    checks++; if (bus.sel_mux !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", bus.sel_mux); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.out_data); end
    checks++; if ({bus.ack_a, bus.ack_b} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {bus.ack_a, bus.ack_b}); end
    @(negedge clk);
    rst = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0; bus.last_a = 1'b0; bus.last_b = 1'b0;
  endtask

  task automatic test_single_a();
    logic [15:0] din  [6] = '{16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000};
    logic [2:0]  ctl  [6] = '{3'b000, 3'b110, 3'b111, 3'b111, 3'b001, 3'b000};  // {grant_a, ack_a, out_valid}
    logic [15:0] dout [6] = '{16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req_a = (i < 4); bus.last_a = (i == 3); bus.data_a = din[i]; bus.out_ready = 1'b1;
      #1;
      checks++; if ({bus.grant_a, bus.ack_a, bus.out_valid} !== ctl[i]) begin errors++; $display("FAIL single_a_ctl[%0d]: got %b want %b", i, {bus.grant_a, bus.ack_a, bus.out_valid}, ctl[i]); end
      checks++; if (bus.sel_mux !== 1'b0) begin errors++; $display("FAIL single_a_sel[%0d]: got %b want 0", i, bus.sel_mux); end
      if (ctl[i][0]) begin
        checks++; if (bus.out_data !== dout[i]) begin errors++; $display("FAIL single_a_data[%0d]: got %h want %h", i, bus.out_data, dout[i]); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [5:0]  ctl  [8] = '{6'b000000, 6'b100100, 6'b000001, 6'b011010,
                              6'b001001, 6'b100100, 6'b000001, 6'b011010};  // {ga, gb, sel, aa, ab, ov}
    logic [15:0] dout [8] = '{16'h0, 16'h0, 16'hAAAA, 16'h0, 16'hBBBB, 16'h0, 16'hAAAA, 16'h0};
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.last_a = 1'b1; bus.last_b = 1'b1;
    bus.data_a = 16'hAAAA; bus.data_b = 16'hBBBB; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({bus.grant_a, bus.grant_b, bus.sel_mux, bus.ack_a, bus.ack_b, bus.out_valid} !== ctl[i]) begin errors++; $display("FAIL rr_ctl[%0d]: got %b want %b", i, {bus.grant_a, bus.grant_b, bus.sel_mux, bus.ack_a, bus.ack_b, bus.out_valid}, ctl[i]); end
      if (ctl[i][0]) begin
        checks++; if (bus.out_data !== dout[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus.out_data, dout[i]); end
      end
    end
    @(negedge clk);
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.last_a = 1'b0; bus.last_b = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hBBBB}) begin errors++; $display("FAIL rr_tail: got %b/%h want 1/bbbb", bus.out_valid, bus.out_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [2:0]  ctl  [10] = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b001, 3'b000};  // {gb, ab, ov}
    logic [15:0] din  [10] = '{16'hBEEF, 16'hBEEF, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0, 16'h0};
    logic [15:0] dout [10] = '{16'h0, 16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0001, 16'h0002, 16'h0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_b = (i < 8); bus.last_b = (i == 7); bus.data_b = din[i];
      bus.out_ready = !(i >= 2 && i <= 5);
      #1;
      checks++; if ({bus.grant_b, bus.ack_b, bus.out_valid} !== ctl[i]) begin errors++; $display("FAIL bp_ctl[%0d]: got %b want %b", i, {bus.grant_b, bus.ack_b, bus.out_valid}, ctl[i]); end
      if (ctl[i][0]) begin
        checks++; if (bus.out_data !== dout[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, bus.out_data, dout[i]); end
      end
      if (ctl[i][2]) begin
        checks++; if (bus.sel_mux !== 1'b1) begin errors++; $display("FAIL bp_sel[%0d]: got %b want 1", i, bus.sel_mux); end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0]  ctl  [9] = '{4'b0000, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b0000, 4'b0101, 4'b0000};  // {ga, gb, aa, ab}
    logic [15:0] dout [9] = '{16'h0, 16'h0, 16'h0A01, 16'h0, 16'h0, 16'h0, 16'h0A02, 16'h0, 16'h0B01};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req_a = (i < 2) || (i == 5); bus.last_a = (i == 5);
      bus.data_a = (i < 2) ? 16'h0A01 : 16'h0A02;
      bus.req_b = (i < 8); bus.last_b = 1'b1; bus.data_b = 16'h0B01; bus.out_ready = 1'b1;
      #1;
      checks++; if ({bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b} !== ctl[i]) begin errors++; $display("FAIL stall_ctl[%0d]: got %b want %b", i, {bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b}, ctl[i]); end
      if (dout[i] != 16'h0) begin
        checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, dout[i]}) begin errors++; $display("FAIL stall_data[%0d]: got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, dout[i]); end
      end
    end
    bus.last_b = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.req_a = 1'b0; bus.req_b = 1'b1; bus.last_b = 1'b0; bus.data_b = 16'h5555; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.grant_b !== 1'b0) begin errors++; $display("FAIL ar_idle_grant: got %b want 0", bus.grant_b); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checks++; if ({bus.grant_b, bus.ack_b} !== 2'b11) begin errors++; $display("FAIL ar_first_ack: got %b want 11", {bus.grant_b, bus.ack_b}); end
    @(negedge clk); #1;
    checks++; if ({bus.out_valid, bus.sel_mux, bus.ack_b, bus.out_data} !== {3'b110, 16'h5555}) begin errors++; $display("FAIL ar_pre: got %b%b%b/%h want 110/5555", bus.out_valid, bus.sel_mux, bus.ack_b, bus.out_data); end
    #2; rst = 1'b1; #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
    checks++; if ({bus.grant_a, bus.grant_b} !== 2'b00) begin errors++; $display("FAIL ar_grants: got %b want 00", {bus.grant_a, bus.grant_b}); end
    checks++; if (bus.sel_mux !== 1'b0) begin errors++; $display("FAIL ar_sel: got %b want 0", bus.sel_mux); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL ar_data: got %h want 0000", bus.out_data); end
    @(negedge clk);
    rst = 1'b0; bus.req_b = 1'b0; bus.req_a = 1'b1; bus.last_a = 1'b1; bus.data_a = 16'h6666; bus.out_ready = 1'b1;
    #1;
    checks++; if ({bus.grant_a, bus.ack_a, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL ar_rearb_idle: got %b want 000", {bus.grant_a, bus.ack_a, bus.out_valid}); end
    @(negedge clk); #1;
    checks++; if ({bus.grant_a, bus.ack_a, bus.sel_mux} !== 3'b110) begin errors++; $display("FAIL ar_rearb_own: got %b want 110", {bus.grant_a, bus.ack_a, bus.sel_mux}); end
    @(negedge clk);
    bus.req_a = 1'b0; bus.last_a = 1'b0;
    #1;
    checks++; if ({bus.grant_a, bus.out_valid, bus.out_data} !== {2'b01, 16'h6666}) begin errors++; $display("FAIL ar_rearb_data: got %b%b/%h want 01/6666", bus.grant_a, bus.out_valid, bus.out_data); end
  endtask

`ifdef ARB_BEAT_LIMIT_EN
  localparam int NCYC = 15;
  localparam logic [3:0] LIM_CTL [NCYC] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0101, 4'b0000,
                                            4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
`else
  localparam int NCYC = 14;
  localparam logic [3:0] LIM_CTL [NCYC] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
                                            4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0101, 4'b0000};
`endif

  task automatic test_beat_limit();
    int          beat = 0;
    bit          have_pend = 1'b0;
    logic [15:0] pend = 16'h0;
    logic [3:0]  exp_ctl;
    for (int i = 0; i < NCYC; i++) begin
      exp_ctl = LIM_CTL[i];
      @(negedge clk);
`ifdef ARB_BEAT_LIMIT_EN
      bus.req_a = (i < 14); bus.req_b = (i >= 1 && i <= 6);
`else
      bus.req_a = (i <= 10); bus.req_b = (i >= 1 && i <= 12);
`endif
      bus.data_a = 16'hA000 + 16'(beat); bus.last_a = (beat == 9);
      bus.data_b = 16'hB000; bus.last_b = 1'b1; bus.out_ready = 1'b1;
      #1;
      checks++; if ({bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b} !== exp_ctl) begin errors++; $display("FAIL limit_ctl[%0d]: got %b want %b", i, {bus.grant_a, bus.grant_b, bus.ack_a, bus.ack_b}, exp_ctl); end
      if (have_pend) begin
        checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, pend}) begin errors++; $display("FAIL limit_data[%0d]: got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, pend); end
      end
      have_pend = exp_ctl[1] || exp_ctl[0];
      pend      = exp_ctl[1] ? 16'hA000 + 16'(beat) : 16'hB000;
      if (exp_ctl[1]) beat++;
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.last_a = 1'b0; bus.last_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_a = 1'b0; bus.last_a = 1'b0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.last_b = 1'b0; bus.data_b = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_a();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_async_reset();
    test_beat_limit();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
